vga_cell_display: RTL and testbench
===================================

Name: vga_cell_display

Overview:
- Parametrised successor to the fixed 40x30 monochrome VGA test block.
- Generates VGA timing from parameters and renders a cell-mapped framebuffer held in internal RAM, not driven as a flat bus.
- Each cell holds a 2-bit colour index, resolved through a writable 4-entry 12-bit palette.
- Sits between the CPU peripheral bus (write port) and the board VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CELL_SHIFT, 4, log2 of cell edge in pixels (16x16 cells)
COLS, 40, cells per row; must equal H_ACTIVE >> CELL_SHIFT
ROWS, 30, cell rows; must equal V_ACTIVE >> CELL_SHIFT
SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_en  in  1  pixel-rate enable; one tick per pixel (25 MHz equivalent)
wr_en  in  1  cell RAM write strobe
wr_addr  in  11  cell index, row*COLS+col
wr_data  in  2  palette index for the cell
pal_we  in  1  palette write strobe
pal_idx  in  2  palette entry to write
pal_rgb  in  12  {R[3:0],G[3:0],B[3:0]}
red_out  out  4  red DAC
green_out  out  4  green DAC
blue_out  out  4  blue DAC
h_sync_out  out  1  horizontal sync
v_sync_out  out  1  vertical sync
h_position  out  12  horizontal counter, aligned with RGB
v_position  out  11  vertical counter, aligned with RGB
pixel_position  out  11  cell index of the displayed pixel (0 when blanked)
frame_start  out  1  one-clk pulse at the first pix_en tick of each frame
vblank  out  1  high while v_position >= V_ACTIVE

Behaviour:
- Reset values:
  - Counters, h_position, v_position, pixel_position: 0.
  - RGB: 0.
  - Syncs: inactive level (~SYNC_POL).
  - frame_start: 0.
  - vblank: 0.
  - Palette: {0:000, 1:FFF, 2:F00, 3:00F}.
  - Cell RAM contents are not reset.
- Reset mid-frame restarts timing at (0,0); pipeline registers are flushed to blank.
- Timing counters:
  - Advance only on pix_en. h wraps at H_TOTAL-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1; v increments on h wrap and wraps at V_TOTAL-1.
  - Without pix_en, all state holds.
- Sync windows:
  - h_sync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - v_sync likewise on v.
- Pipeline: 2 pix_en ticks of latency.
  - S0: counters, plus cell address (v>>CELL_SHIFT)*COLS + (h>>CELL_SHIFT), plus active flag.
  - S1: synchronous RAM read and palette read.
  - S2: registered RGB/sync/position outputs.
  - Syncs, positions and active flag travel through matching delay stages, so all outputs are mutually aligned.
- Blanking: RGB forced to 0 when the aligned pixel is outside the active area.
- Cell RAM:
  - COLS*ROWS x 2 bits, single write port plus single read port.
  - Write and read at the same address on the same clk: read returns old data (read-first).
  - wr_addr >= COLS*ROWS: write ignored.
- Palette:
  - pal_we takes effect the next clk.
  - Takes effect mid-line; no frame buffering.
- frame_start: asserted for exactly one clk when the aligned output position becomes (0,0).
- Widths: the multiply uses constant COLS, so synthesis reduces it to shifts/adds. Counter widths are fixed at 12 and 11 bits; H_TOTAL must be <= 4096 and V_TOTAL <= 2048.

Decomposition:
- Shared package vga_pkg:
  - Timing parameter defaults and the H_TOTAL/V_TOTAL derivation.
  - The default palette constants.
  - The RGB 12-bit packing typedef.
- One natural sub-module, vga_timing_gen: counters, sync windows, vblank and active flag.
- Cell RAM and palette stay inline in vga_cell_display.

Test Plan:
- Reset, then pix_en every clk for one frame:
  - h_sync low for 96 ticks starting at h=656.
  - v_sync low on lines 490-491.
  - 800x525 ticks per frame.
  - frame_start pulses once.
- Write cell 0 = 1, cell 41 = 2, everything else 0:
  - pixel (0,0) outputs FFF.
  - pixel (16,16) outputs F00.
  - pixel (15,15) outputs FFF.
  - pixel (32,0) outputs 000.
  - Each result appears 2 ticks after the counter reaches the pixel.
- pal_we idx=1 rgb=0A5 mid-line: pixels in cells of index 1 change to 0A5 starting 2 ticks after the write; earlier pixels on that line are unaffected.
- wr_addr=1200 with wr_data=3: no RAM change; cell 0 still renders its previous colour.
- pix_en toggling every 2nd clk: outputs hold between ticks, and the frame takes 2x800x525 clks.
- Assert reset at h=300, v=200:
  - Next clk: RGB=0, syncs inactive.
  - After release: h_position/v_position restart from 0.
  - frame_start pulses at the first aligned (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, default palette and 12-bit RGB packing for the VGA cell display.
package vga_pkg;

  localparam int unsigned HActiveDef   = 640;
  localparam int unsigned HFpDef       = 16;
  localparam int unsigned HSyncDef     = 96;
  localparam int unsigned HBpDef       = 48;
  localparam int unsigned VActiveDef   = 480;
  localparam int unsigned VFpDef       = 10;
  localparam int unsigned VSyncDef     = 2;
  localparam int unsigned VBpDef       = 33;
  localparam int unsigned CellShiftDef = 4;
  localparam int unsigned ColsDef      = 40;
  localparam int unsigned RowsDef      = 30;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t PalDef0 = 12'h000;
  localparam rgb_t PalDef1 = 12'hFFF;
  localparam rgb_t PalDef2 = 12'hF00;
  localparam rgb_t PalDef3 = 12'h00F;

  // Total pixels per line (or lines per frame) including porches and sync.
  function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with sync windows, active-area and vertical-blank flags (pipeline stage 0).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned H_FP     = HFpDef,
  parameter int unsigned H_SYNC   = HSyncDef,
  parameter int unsigned H_BP     = HBpDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned V_FP     = VFpDef,
  parameter int unsigned V_SYNC   = VSyncDef,
  parameter int unsigned V_BP     = VBpDef,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [11:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        h_sync,
  output logic        v_sync,
  output logic        active,
  output logic        vblank
);

  localparam int unsigned HTotal = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [11:0] HLast    = 12'(HTotal - 1);
  localparam logic [11:0] HActEnd  = 12'(H_ACTIVE);
  localparam logic [11:0] HsFirst  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HsLast   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VLast    = 11'(VTotal - 1);
  localparam logic [10:0] VActEnd  = 11'(V_ACTIVE);
  localparam logic [10:0] VsFirst  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsLast   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 12'd1;
      end
    end
  end

  always_comb begin
    h_cnt  = h_q;
    v_cnt  = v_q;
    h_sync = ((h_q >= HsFirst) && (h_q <= HsLast)) ? SYNC_POL : ~SYNC_POL;
    v_sync = ((v_q >= VsFirst) && (v_q <= VsLast)) ? SYNC_POL : ~SYNC_POL;
    active = (h_q < HActEnd) && (v_q < VActEnd);
    vblank = (v_q >= VActEnd);
  end

endmodule

// File: rtl/vga_cell_display.sv
// VGA output of a cell-mapped 2-bit framebuffer through a writable 4-entry palette.
// Pipeline: S0 counters/address, S1 cell RAM read, S2 registered outputs (2 pix_en ticks).
module vga_cell_display
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = HActiveDef,
  parameter int unsigned H_FP       = HFpDef,
  parameter int unsigned H_SYNC     = HSyncDef,
  parameter int unsigned H_BP       = HBpDef,
  parameter int unsigned V_ACTIVE   = VActiveDef,
  parameter int unsigned V_FP       = VFpDef,
  parameter int unsigned V_SYNC     = VSyncDef,
  parameter int unsigned V_BP       = VBpDef,
  parameter int unsigned CELL_SHIFT = CellShiftDef,
  parameter int unsigned COLS       = ColsDef,
  parameter int unsigned ROWS       = RowsDef,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        wr_en,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_data,
  input  logic        pal_we,
  input  logic [1:0]  pal_idx,
  input  logic [11:0] pal_rgb,
  output logic [3:0]  red_out,
  output logic [3:0]  green_out,
  output logic [3:0]  blue_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [11:0] h_position,
  output logic [10:0] v_position,
  output logic [10:0] pixel_position,
  output logic        frame_start,
  output logic        vblank
);

  localparam int unsigned Cells    = COLS * ROWS;
  localparam int unsigned AddrW    = $clog2(Cells);
  localparam logic [10:0] CellsEnd = 11'(Cells);

  // Stage 0
  logic [11:0] h0;
  logic [10:0] v0;
  logic        hs0, vs0, act0, vb0;
  logic [10:0] cell_row, cell_col, cell_addr;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .h_cnt  (h0),
    .v_cnt  (v0),
    .h_sync (hs0),
    .v_sync (vs0),
    .active (act0),
    .vblank (vb0)
  );

  // Address is forced to 0 outside the active area so the RAM index stays in range.
  assign cell_row  = v0 >> CELL_SHIFT;
  assign cell_col  = 11'(h0 >> CELL_SHIFT);
  assign cell_addr = act0 ? (cell_row * 11'(COLS)) + cell_col : '0;

  // Cell RAM: read-first, no reset; out-of-range writes are dropped.
  logic [1:0] cell_mem [Cells];
  logic [1:0] cell_rd_q;

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < CellsEnd)) begin
      cell_mem[wr_addr[AddrW-1:0]] <= wr_data;
    end
    if (pix_en) begin
      cell_rd_q <= cell_mem[cell_addr[AddrW-1:0]];
    end
  end

  rgb_t pal_q [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      pal_q[0] <= PalDef0;
      pal_q[1] <= PalDef1;
      pal_q[2] <= PalDef2;
      pal_q[3] <= PalDef3;
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_rgb;
    end
  end

  // Stage 1 sidebands; s1_valid keeps the flushed (0,0) from raising frame_start.
  logic        s1_valid, s1_act, s1_hs, s1_vs, s1_vb;
  logic [11:0] s1_h;
  logic [10:0] s1_v, s1_addr;

  // Stage 2 outputs
  rgb_t        rgb_q, rgb_d;
  logic        hs_q, vs_q, vb_q, fs_q, fs_d;
  logic [11:0] h_q;
  logic [10:0] v_q, addr_q;

  always_comb begin
    rgb_d = s1_act ? pal_q[cell_rd_q] : '0;
    fs_d  = pix_en && s1_valid && (s1_h == '0) && (s1_v == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_act   <= 1'b0;
      s1_hs    <= ~SYNC_POL;
      s1_vs    <= ~SYNC_POL;
      s1_vb    <= 1'b0;
      s1_h     <= '0;
      s1_v     <= '0;
      s1_addr  <= '0;
      rgb_q    <= '0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      vb_q     <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= '0;
      fs_q     <= 1'b0;
    end else begin
      fs_q <= fs_d;
      if (pix_en) begin
        s1_valid <= 1'b1;
        s1_act   <= act0;
        s1_hs    <= hs0;
        s1_vs    <= vs0;
        s1_vb    <= vb0;
        s1_h     <= h0;
        s1_v     <= v0;
        s1_addr  <= cell_addr;
        rgb_q    <= rgb_d;
        hs_q     <= s1_hs;
        vs_q     <= s1_vs;
        vb_q     <= s1_vb;
        h_q      <= s1_h;
        v_q      <= s1_v;
        addr_q   <= s1_addr;
      end
    end
  end

  always_comb begin
    red_out        = rgb_q.r;
    green_out      = rgb_q.g;
    blue_out       = rgb_q.b;
    h_sync_out     = hs_q;
    v_sync_out     = vs_q;
    h_position     = h_q;
    v_position     = v_q;
    pixel_position = addr_q;
    frame_start    = fs_q;
    vblank         = vb_q;
  end

endmodule

// File: tb/tb_vga_cell_display.sv
// Self-checking bench for vga_cell_display on a reduced 200x42 frame with 10x2 cells.
module tb_vga_cell_display;

  localparam int HA = 160, HF = 8, HS = 24, HB = 8;
  localparam int VA = 32, VF = 3, VS = 2, VB = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int COLS = 10, ROWS = 2;
  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        reset, pix_en, wr_en, pal_we;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data, pal_idx;
  logic [11:0] pal_rgb;
  logic [3:0]  red_out, green_out, blue_out;
  logic        h_sync_out, v_sync_out, frame_start, vblank;
  logic [11:0] h_position;
  logic [10:0] v_position, pixel_position;
  logic [11:0] rgb;

  assign rgb = {red_out, green_out, blue_out};

  vga_cell_display #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CELL_SHIFT (4), .COLS (COLS), .ROWS (ROWS), .SYNC_POL (1'b0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pix_en         (pix_en),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .pal_we         (pal_we),
    .pal_idx        (pal_idx),
    .pal_rgb        (pal_rgb),
    .red_out        (red_out),
    .green_out      (green_out),
    .blue_out       (blue_out),
    .h_sync_out     (h_sync_out),
    .v_sync_out     (v_sync_out),
    .h_position     (h_position),
    .v_position     (v_position),
    .pixel_position (pixel_position),
    .frame_start    (frame_start),
    .vblank         (vblank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v; int rgb; int pos; int hs; int vs; int vb;
  } vec_t;

  vec_t vecs [NV];
  int total = 0;
  int bad = 0;
  int n = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (tick %0d)", name, act, exp, n);
    end
  endtask

  // n counts pix_en ticks since the last reset release.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pix_en) n++;
  endtask

  task automatic adv_to(input int target);
    while (n < target) tick();
  endtask

  initial begin
    int vi, nz_cnt, fff_cnt, vb_cnt, hs_low, hs_first, vs_lines, vs_first;
    int fs_cnt, fs_first, fs_last, fs_seen, pos_err, exp_p, base;
    int fs_clk [2];

    vecs[0]  = '{0,   0,  12'hFFF, 0,  1, 1, 0};
    vecs[1]  = '{15,  0,  12'hFFF, 0,  1, 1, 0};
    vecs[2]  = '{16,  0,  12'h000, 1,  1, 1, 0};
    vecs[3]  = '{32,  0,  12'h000, 2,  1, 1, 0};
    vecs[4]  = '{159, 0,  12'h000, 9,  1, 1, 0};
    vecs[5]  = '{160, 0,  12'h000, 0,  1, 1, 0};
    vecs[6]  = '{167, 0,  12'h000, 0,  1, 1, 0};
    vecs[7]  = '{168, 0,  12'h000, 0,  0, 1, 0};
    vecs[8]  = '{191, 0,  12'h000, 0,  0, 1, 0};
    vecs[9]  = '{192, 0,  12'h000, 0,  1, 1, 0};
    vecs[10] = '{15,  15, 12'hFFF, 0,  1, 1, 0};
    vecs[11] = '{0,   16, 12'h000, 10, 1, 1, 0};
    vecs[12] = '{16,  16, 12'hF00, 11, 1, 1, 0};
    vecs[13] = '{32,  16, 12'h000, 12, 1, 1, 0};
    vecs[14] = '{31,  31, 12'hF00, 11, 1, 1, 0};
    vecs[15] = '{159, 31, 12'h000, 19, 1, 1, 0};
    vecs[16] = '{0,   32, 12'h000, 0,  1, 1, 1};
    vecs[17] = '{0,   34, 12'h000, 0,  1, 1, 1};
    vecs[18] = '{0,   35, 12'h000, 0,  1, 0, 1};
    vecs[19] = '{0,   36, 12'h000, 0,  1, 0, 1};
    vecs[20] = '{0,   37, 12'h000, 0,  1, 1, 1};
    vecs[21] = '{199, 41, 12'h000, 0,  1, 1, 1};

    reset = 1'b1; pix_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pal_we = 1'b0; pal_idx = '0; pal_rgb = '0;
    tick();
    tick();
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", h_sync_out, 1);
    chk("rst_vsync", v_sync_out, 1);
    chk("rst_hpos", h_position, 0);
    chk("rst_vpos", v_position, 0);
    chk("rst_ppos", pixel_position, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_vblank", vblank, 0);
    reset = 1'b0;

    // Load cells with pix_en low: cell 0 = 1, cell 11 = 2, rest 0.
    for (int i = 0; i < COLS * ROWS; i++) begin
      wr_en = 1'b1;
      wr_addr = 11'(i);
      wr_data = (i == 0) ? 2'd1 : ((i == 11) ? 2'd2 : 2'd0);
      tick();
    end
    wr_en = 1'b0;
    chk("idle_hold_h", h_position, 0);
    chk("idle_hold_fs", frame_start, 0);

    // Frame 0: table vectors plus whole-frame statistics.
    n = 0; pix_en = 1'b1; vi = 0;
    nz_cnt = 0; fff_cnt = 0; vb_cnt = 0; hs_low = 0; hs_first = -1;
    vs_lines = 0; vs_first = -1; fs_cnt = 0; fs_first = -1; fs_last = -1;
    for (int k = 1; k <= FT + 3; k++) begin
      tick();
      if (vi < NV && n == vecs[vi].v * HT + vecs[vi].h + 2) begin
        chk($sformatf("v%0d_rgb", vi), rgb, vecs[vi].rgb);
        chk($sformatf("v%0d_hpos", vi), h_position, vecs[vi].h);
        chk($sformatf("v%0d_vpos", vi), v_position, vecs[vi].v);
        chk($sformatf("v%0d_ppos", vi), pixel_position, vecs[vi].pos);
        chk($sformatf("v%0d_hsync", vi), h_sync_out, vecs[vi].hs);
        chk($sformatf("v%0d_vsync", vi), v_sync_out, vecs[vi].vs);
        chk($sformatf("v%0d_vblank", vi), vblank, vecs[vi].vb);
        vi++;
      end
      if (n >= 2 && n <= FT + 1) begin
        if (rgb != 0) nz_cnt++;
        if (rgb == 12'hFFF) fff_cnt++;
        if (vblank) vb_cnt++;
        if (h_position == 0 && !v_sync_out) begin
          if (vs_lines == 0) vs_first = v_position;
          vs_lines++;
        end
      end
      if (n >= 2 && n <= HT + 1 && !h_sync_out) begin
        if (hs_low == 0) hs_first = h_position;
        hs_low++;
      end
      if (frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = n;
        else fs_last = n;
      end
    end
    chk("vec_reached", vi, NV);
    chk("lit_pixels", nz_cnt, 512);
    chk("white_pixels", fff_cnt, 256);
    chk("vblank_ticks", vb_cnt, (VT - VA) * HT);
    chk("hsync_len", hs_low, HS);
    chk("hsync_first", hs_first, HA + HF);
    chk("vsync_lines", vs_lines, VS);
    chk("vsync_first", vs_first, VA + VF);
    chk("fs_count", fs_cnt, 2);
    chk("fs_first_tick", fs_first, 2);
    chk("frame_ticks", fs_last - fs_first, FT);

    // Frame 1: mid-line palette rewrite of entry 1.
    adv_to(FT + 5 + 2);
    chk("pal_before", rgb, 12'hFFF);
    pal_we = 1'b1; pal_idx = 2'd1; pal_rgb = 12'h0A5;
    tick();
    pal_we = 1'b0;
    tick();
    tick();
    chk("pal_after", rgb, 12'h0A5);
    tick();
    chk("pal_after2", rgb, 12'h0A5);
    adv_to(FT + 15 + 2);
    chk("pal_cell_end", rgb, 12'h0A5);

    // Out-of-range writes ignored; last valid cell written.
    wr_en = 1'b1; wr_data = 2'd3;
    wr_addr = 11'd1200; tick();
    wr_addr = 11'(COLS * ROWS); tick();
    wr_addr = 11'(COLS * ROWS - 1); tick();
    wr_en = 1'b0;

    // Read-first: write cell 11 on the same edge that reads it for pixel (16,16).
    adv_to(FT + 16 * HT + 16);
    wr_en = 1'b1; wr_addr = 11'd11; wr_data = 2'd3;
    tick();
    wr_en = 1'b0;
    tick();
    chk("rf_old", rgb, 12'hF00);
    tick();
    chk("rf_new", rgb, 12'h00F);

    // Frame 2: results of the writes.
    adv_to(2 * FT + 2);
    chk("oor_cell0", rgb, 12'h0A5);
    adv_to(2 * FT + 16 * HT + 15 + 2);
    chk("cell10", rgb, 12'h000);
    adv_to(2 * FT + 16 * HT + 16 + 2);
    chk("cell11_new", rgb, 12'h00F);
    adv_to(2 * FT + 31 * HT + 159 + 2);
    chk("last_cell_rgb", rgb, 12'h00F);
    chk("last_cell_ppos", pixel_position, COLS * ROWS - 1);

    // pix_en every 2nd clk: outputs track tick count, frame spans 2*FT clks.
    fs_seen = 0; pos_err = 0; fs_clk[0] = 0; fs_clk[1] = 0;
    for (int c = 0; c < 6 * FT && fs_seen < 2; c++) begin
      pix_en = (c % 2 == 1);
      tick();
      exp_p = (n - 2) % FT;
      if (h_position != 12'(exp_p % HT) || v_position != 11'(exp_p / HT)) pos_err++;
      if (frame_start) begin
        fs_clk[fs_seen] = c;
        fs_seen++;
      end
    end
    chk("tog_fs_seen", fs_seen, 2);
    chk("tog_frame_clks", fs_clk[1] - fs_clk[0], 2 * FT);
    chk("tog_hold", pos_err, 0);

    // Reset inside both sync windows.
    pix_en = 1'b1;
    base = (n / FT + 1) * FT;
    adv_to(base + 36 * HT + 180);
    chk("pre_rst_hsync", h_sync_out, 0);
    chk("pre_rst_vsync", v_sync_out, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_hsync", h_sync_out, 1);
    chk("mid_rst_vsync", v_sync_out, 1);
    chk("mid_rst_hpos", h_position, 0);
    chk("mid_rst_vpos", v_position, 0);
    reset = 1'b0;
    n = 0;
    tick();
    chk("restart1_hpos", h_position, 0);
    chk("restart1_fs", frame_start, 0);
    tick();
    chk("restart2_fs", frame_start, 1);
    chk("restart2_vpos", v_position, 0);
    chk("restart2_rgb", rgb, 12'hFFF);
    tick();
    chk("restart3_hpos", h_position, 1);
    chk("restart3_fs", frame_start, 0);

    // Reset while a lit pixel is on the output.
    adv_to(20 * HT + 20);
    chk("pre_rst2_rgb", rgb, 12'h00F);
    reset = 1'b1;
    tick();
    chk("rst2_rgb", rgb, 0);
    chk("rst2_ppos", pixel_position, 0);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
